// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the MIPS8 datapath.
// Latency: 3 to 5 cycles per instruction with zero-wait memories, plus one cycle per memory wait.
// Backpressure: stalls in FETCH until im_ready and in MEM until dm_ready (optional timeout abort).
//
// Ports: clk/rst_n (async active-low); halt blocks new fetches; im_opcode/im_ready
// instruction memory; dm_ready data memory completion; flag_z/l/g for conditional
// jumps. Outputs drive PC, IR, register file, flags, data memory, datapath mux
// selects and alu_func, plus illegal_op/bus_error pulses, retired count, debug state.
module multicycle_control_unit #(
    parameter int OPCODE_W   = 5,
    parameter int ALU_FUNC_W = 3,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic [OPCODE_W-1:0]   im_opcode,
    input  logic                  im_ready,
    input  logic                  dm_ready,
    input  logic                  flag_z,
    input  logic                  flag_l,
    input  logic                  flag_g,
    output logic                  im_req,
    output logic                  ir_write,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  dm_req,
    output logic                  dm_write,
    output logic                  reg_write,
    output logic                  flags_write,
    output logic                  is_move,
    output logic                  is_mem_access,
    output logic                  is_li,
    output logic                  is_imm,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  illegal_op,
    output logic                  bus_error,
    output logic [CNT_W-1:0]      retired,
    output logic [2:0]            state
);

    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_LI   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_JNZ  = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_JG   = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_JL   = OPCODE_W'(16);
    localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(17);

    // Wait counter only needs to reach TIMEOUT-1: the abort fires in the
    // TIMEOUT-th MEM cycle if dm_ready is still low.
    localparam int WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       is_move;
        logic       is_mem_access;
        logic       is_li;
        logic       is_imm;
        logic [2:0] alu;
    } sel_t;

    // Undefined opcodes fall through to the all-zero (NOP) selects.
    function automatic sel_t decode_sel(input logic [OPCODE_W-1:0] op);
        sel_t s;
        s = '0;
        case (op)
            OP_ADD:       s.alu = 3'd1;
            OP_ADDI:      begin s.alu = 3'd1; s.is_imm = 1'b1; end
            OP_SUB,
            OP_CMP:       s.alu = 3'd2;
            OP_SUBI:      begin s.alu = 3'd2; s.is_imm = 1'b1; end
            OP_AND:       s.alu = 3'd3;
            OP_OR:        s.alu = 3'd4;
            OP_XOR:       s.alu = 3'd5;
            OP_MOV:       s.is_move = 1'b1;
            OP_LW, OP_SW: s.is_mem_access = 1'b1;
            OP_LI:        s.is_li = 1'b1;
            default:      s = '0;
        endcase
        return s;
    endfunction

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    sel_t                  sel_q, sel_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic fetch_fire;
    logic retire;
    logic timeout_hit;
    logic op_illegal, op_sets_flags, op_needs_wb, op_is_mem, take_jump;

    // Instruction class of the latched opcode.
    always_comb begin
        op_illegal    = (op_q > OPCODE_W'(17));
        op_sets_flags = 1'b0;
        op_needs_wb   = 1'b0;
        op_is_mem     = 1'b0;
        take_jump     = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_ADDI, OP_SUBI: begin
                op_sets_flags = 1'b1;
                op_needs_wb   = 1'b1;
            end
            OP_CMP:         op_sets_flags = 1'b1;
            OP_MOV, OP_LI:  op_needs_wb   = 1'b1;
            OP_LW, OP_SW:   op_is_mem     = 1'b1;
            OP_JZ:          take_jump     = flag_z;
            OP_JNZ:         take_jump     = ~flag_z;
            OP_JG:          take_jump     = flag_g;
            OP_JL:          take_jump     = flag_l;
            OP_JUMP:        take_jump     = 1'b1;
            default:        ;
        endcase
    end

    assign fetch_fire  = (state_q == S_FETCH) && !halt && im_ready;
    assign timeout_hit = (TIMEOUT > 0) && (state_q == S_MEM) && !dm_ready &&
                         (wait_q == WAIT_W'(TO_LAST));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_fire) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op_is_mem)        state_d = S_MEM;
                else if (op_needs_wb) state_d = S_WB;
                else                  state_d = S_FETCH;
            end
            S_MEM: begin
                if (dm_ready)         state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout_hit) state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // FSM outputs
    always_comb begin
        im_req      = 1'b0;
        ir_write    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        dm_req      = 1'b0;
        dm_write    = 1'b0;
        reg_write   = 1'b0;
        flags_write = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_req   = ~halt;
                ir_write = fetch_fire;
                pc_inc   = fetch_fire;
            end
            S_DECODE: illegal_op = op_illegal;
            S_EXEC: begin
                flags_write = op_sets_flags;
                pc_load     = take_jump;
                retire      = !op_is_mem && !op_needs_wb;
            end
            S_MEM: begin
                dm_req    = 1'b1;
                dm_write  = (op_q == OP_SW);
                bus_error = timeout_hit;
                retire    = dm_ready && (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Opcode, selects, wait counter and retire counter.
    // Selects load alongside op_q so they are valid from DECODE until the next fetch.
    always_comb begin
        op_d      = fetch_fire ? im_opcode : op_q;
        sel_d     = fetch_fire ? decode_sel(im_opcode) : sel_q;
        wait_d    = wait_q;
        if (state_q == S_EXEC) begin
            wait_d = '0;
        end else if (state_q == S_MEM && TIMEOUT > 0) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            sel_q     <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            op_q      <= op_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign is_move       = sel_q.is_move;
    assign is_mem_access = sel_q.is_mem_access;
    assign is_li         = sel_q.is_li;
    assign is_imm        = sel_q.is_imm;
    assign alu_func      = ALU_FUNC_W'(sel_q.alu);
    assign retired       = retired_q;
    assign state         = state_q;

endmodule
